// File: rtl/parity_frame_checker.sv
// parity_frame_checker
// Multi-channel serial parity checker. Each channel accepts one qualified bit
// per clock, keeps the running parity of the current frame and counts parity
// transitions (saturating, cumulative until reset). It reports a parity error
// at the end of each FRAME_LEN-bit frame; the last bit of the frame is the
// parity bit.
// Optional build macro: PARITY_ERR_CNT_EN adds parameter ERR_W and output
// err_cnt, a per-channel saturating count of frames that ended in error.
module parity_frame_checker #(
  parameter int NUM_CH     = 2,
  parameter int FRAME_LEN  = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 6
`ifdef PARITY_ERR_CNT_EN
  , parameter int ERR_W    = 8
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       data_in,
  input  logic [NUM_CH-1:0]       valid_in,
  input  logic [NUM_CH-1:0]       abort,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       parity_out,
  output logic [NUM_CH-1:0]       frame_done,
  output logic [NUM_CH-1:0]       parity_err,
  output logic [NUM_CH*CNT_W-1:0] toggle_cnt
`ifdef PARITY_ERR_CNT_EN
  , output logic [NUM_CH*ERR_W-1:0] err_cnt
`endif
);

  // Bit counter only has to hold 0..FRAME_LEN-1.
  localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(FRAME_LEN - 1);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
  localparam logic [CNT_W-1:0] TOG_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TOG_ONE  = CNT_W'(1);
`ifdef PARITY_ERR_CNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state_r, state_nxt_s;
    logic [BC_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic             parity_r, parity_nxt_s;
    logic             par_acc_s;
    logic             last_s;
    logic             done_r, done_nxt_s;
    logic             err_r, err_nxt_s;
    logic             busy_r;
    logic [CNT_W-1:0] tog_r, tog_nxt_s;

    // Next-state and next-output logic for one channel; abort beats valid.
    always_comb begin
      state_nxt_s   = state_r;
      bit_cnt_nxt_s = bit_cnt_r;
      parity_nxt_s  = parity_r;
      done_nxt_s    = 1'b0;
      err_nxt_s     = err_r;
      tog_nxt_s     = tog_r;
      par_acc_s     = parity_r ^ data_in[g];
      last_s        = 1'b0;

      // A frame of length 1 completes straight from IDLE.
      case (state_r)
        ST_IDLE: last_s = (FRAME_LEN == 1);
        ST_RUN:  last_s = (bit_cnt_r == LAST_IDX);
        default: last_s = 1'b0;
      endcase

      if (abort[g]) begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = '0;
        parity_nxt_s  = 1'b0;
      end else if (valid_in[g]) begin
        if (data_in[g] && (tog_r != TOG_MAX)) begin
          tog_nxt_s = tog_r + TOG_ONE;
        end else begin
          tog_nxt_s = tog_r;
        end
        if (last_s) begin
          state_nxt_s   = ST_IDLE;
          bit_cnt_nxt_s = '0;
          parity_nxt_s  = 1'b0;
          done_nxt_s    = 1'b1;
          err_nxt_s     = (par_acc_s != ODD_PARITY);
        end else begin
          state_nxt_s   = ST_RUN;
          bit_cnt_nxt_s = bit_cnt_r + BC_ONE;
          parity_nxt_s  = par_acc_s;
        end
      end else begin
        state_nxt_s = state_r;
      end

      // An illegal state encoding recovers to a clean IDLE.
      if ((state_r != ST_IDLE) && (state_r != ST_RUN)) begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = '0;
        parity_nxt_s  = 1'b0;
      end else begin
        parity_nxt_s  = parity_nxt_s;
      end
    end

    // Channel state and output registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= '0;
        parity_r  <= 1'b0;
        done_r    <= 1'b0;
        err_r     <= 1'b0;
        busy_r    <= 1'b0;
        tog_r     <= '0;
      end else begin
        state_r   <= state_nxt_s;
        bit_cnt_r <= bit_cnt_nxt_s;
        parity_r  <= parity_nxt_s;
        done_r    <= done_nxt_s;
        err_r     <= err_nxt_s;
        busy_r    <= (state_nxt_s == ST_RUN);
        tog_r     <= tog_nxt_s;
      end
    end

    assign busy[g]                    = busy_r;
    assign parity_out[g]              = parity_r;
    assign frame_done[g]              = done_r;
    assign parity_err[g]              = err_r;
    assign toggle_cnt[g*CNT_W +: CNT_W] = tog_r;

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_W-1:0] ecnt_r;

    // Count errored frames so the count moves together with frame_done.
    always_ff @(posedge clk) begin
      if (rst) begin
        ecnt_r <= '0;
      end else if (done_nxt_s && err_nxt_s && (ecnt_r != ERR_MAX)) begin
        ecnt_r <= ecnt_r + ERR_ONE;
      end else begin
        ecnt_r <= ecnt_r;
      end
    end

    assign err_cnt[g*ERR_W +: ERR_W] = ecnt_r;
`endif
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Testbench for parity_frame_checker: directed scenarios plus randomized
// traffic, every cycle compared against a frame-level reference model that
// counts bits and ones per frame.
module tb_parity_frame_checker;

  localparam int NUM_CH    = 2;
  localparam int FRAME_LEN = 8;
  localparam bit ODD       = 1'b0;
  localparam int CNT_W     = 6;
  localparam int TOG_SAT   = 63;
`ifdef PARITY_ERR_CNT_EN
  localparam int ERR_W     = 8;
`endif

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       data_in;
  logic [NUM_CH-1:0]       valid_in;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       parity_out;
  logic [NUM_CH-1:0]       frame_done;
  logic [NUM_CH-1:0]       parity_err;
  logic [NUM_CH*CNT_W-1:0] toggle_cnt;
`ifdef PARITY_ERR_CNT_EN
  logic [NUM_CH*ERR_W-1:0] err_cnt;
`endif

  parity_frame_checker #(
    .NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN), .ODD_PARITY(ODD), .CNT_W(CNT_W)
`ifdef PARITY_ERR_CNT_EN
    , .ERR_W(ERR_W)
`endif
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .abort(abort), .busy(busy), .parity_out(parity_out),
    .frame_done(frame_done), .parity_err(parity_err), .toggle_cnt(toggle_cnt)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-channel bit count, ones count, totals.
  int m_bits [NUM_CH];
  int m_ones [NUM_CH];
  int m_tog  [NUM_CH];
  int m_err  [NUM_CH];
  int m_done [NUM_CH];
  int m_errc [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [NUM_CH-1:0] d, input logic [NUM_CH-1:0] v,
                              input logic [NUM_CH-1:0] a, input logic r);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_done[ch] = 0;
      if (r) begin
        m_bits[ch] = 0; m_ones[ch] = 0; m_tog[ch] = 0; m_err[ch] = 0; m_errc[ch] = 0;
      end else if (a[ch]) begin
        m_bits[ch] = 0; m_ones[ch] = 0;
      end else if (v[ch]) begin
        m_bits[ch] = m_bits[ch] + 1;
        if (d[ch]) begin
          m_ones[ch] = m_ones[ch] + 1;
          if (m_tog[ch] < TOG_SAT) m_tog[ch] = m_tog[ch] + 1;
        end
        if (m_bits[ch] == FRAME_LEN) begin
          m_done[ch] = 1;
          m_err[ch]  = ((m_ones[ch] % 2) != int'(ODD)) ? 1 : 0;
          if (m_err[ch] == 1 && m_errc[ch] < 255) m_errc[ch] = m_errc[ch] + 1;
          m_bits[ch] = 0;
          m_ones[ch] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      chk($sformatf("busy%0d", ch),   32'(busy[ch]),       32'(m_bits[ch] > 0));
      chk($sformatf("parity%0d", ch), 32'(parity_out[ch]), 32'(m_ones[ch] % 2));
      chk($sformatf("done%0d", ch),   32'(frame_done[ch]), 32'(m_done[ch]));
      chk($sformatf("err%0d", ch),    32'(parity_err[ch]), 32'(m_err[ch]));
      chk($sformatf("tog%0d", ch),    32'(toggle_cnt[ch*CNT_W +: CNT_W]), 32'(m_tog[ch]));
`ifdef PARITY_ERR_CNT_EN
      chk($sformatf("errcnt%0d", ch), 32'(err_cnt[ch*ERR_W +: ERR_W]), 32'(m_errc[ch]));
`endif
    end
  endtask

  // Apply inputs for one clock, advance the model, compare after the edge.
  task automatic step(input logic [NUM_CH-1:0] d, input logic [NUM_CH-1:0] v,
                      input logic [NUM_CH-1:0] a, input logic r);
    data_in = d; valid_in = v; abort = a; rst = r;
    @(posedge clk);
    model_update(d, v, a, r);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(2'b00, 2'b00, 2'b00, 1'b1);
  endtask

  logic [7:0] t1_bits;
  logic [7:0] t2_bits;
  logic [NUM_CH-1:0] rd, rv, ra;
  logic rr;

  initial begin
    data_in = '0; valid_in = '0; abort = '0; rst = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_bits[ch] = 0; m_ones[ch] = 0; m_tog[ch] = 0;
      m_err[ch] = 0; m_done[ch] = 0; m_errc[ch] = 0;
    end
    @(negedge clk);
    do_reset();
    do_reset();

    // 1. Good frame 1,0,1,1,0,0,0,1 on ch0.
    t1_bits = 8'b1000_1101;  // bit k of the frame at index k
    for (int k = 0; k < 8; k++) begin
      step({1'b0, t1_bits[k]}, 2'b01, 2'b00, 1'b0);
      if (k < 7) chk("t1_busy_mid", 32'(busy[0]), 32'd1);
    end
    chk("t1_done", 32'(frame_done[0]), 32'd1);
    chk("t1_err", 32'(parity_err[0]), 32'd0);
    chk("t1_tog", 32'(toggle_cnt[0 +: CNT_W]), 32'd4);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("t1_pulse_once", 32'(frame_done[0]), 32'd0);

    // 2. Bad frame 1,0,0,0,0,0,0,0 with a 3-cycle gap after bit 4.
    do_reset();
    t2_bits = 8'b0000_0001;
    for (int k = 0; k < 8; k++) begin
      step({1'b0, t2_bits[k]}, 2'b01, 2'b00, 1'b0);
      if (k == 3) begin
        for (int g = 0; g < 3; g++) step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t2_gap_busy", 32'(busy[0]), 32'd1);
      end
    end
    chk("t2_done", 32'(frame_done[0]), 32'd1);
    for (int g = 0; g < 5; g++) begin
      step(2'b00, 2'b00, 2'b00, 1'b0);
      chk("t2_err_held", 32'(parity_err[0]), 32'd1);
    end

    // 3. Abort on ch1 after 4 ones, abort collides with valid, then 8 zeros.
    do_reset();
    for (int k = 0; k < 4; k++) step(2'b10, 2'b10, 2'b00, 1'b0);
    step(2'b10, 2'b10, 2'b10, 1'b0);
    chk("t3_abort_idle", 32'(busy[1]), 32'd0);
    chk("t3_abort_nodone", 32'(frame_done[1]), 32'd0);
    for (int k = 0; k < 8; k++) step(2'b00, 2'b10, 2'b00, 1'b0);
    chk("t3_done", 32'(frame_done[1]), 32'd1);
    chk("t3_err", 32'(parity_err[1]), 32'd0);
    chk("t3_tog", 32'(toggle_cnt[CNT_W +: CNT_W]), 32'd4);
    step(2'b00, 2'b00, 2'b01, 1'b0);  // abort in IDLE on ch0: no effect

    // 4. Saturation: 80 ones on ch0.
    do_reset();
    for (int k = 0; k < 80; k++) begin
      step(2'b01, 2'b01, 2'b00, 1'b0);
      if (frame_done[0]) chk("t4_err", 32'(parity_err[0]), 32'd0);
    end
    chk("t4_sat", 32'(toggle_cnt[0 +: CNT_W]), 32'd63);

    // 5. Back-to-back on both channels, ch1 offset by 3 cycles.
    do_reset();
    for (int k = 0; k < 21; k++) begin
      logic [NUM_CH-1:0] v5, d5;
      v5[0] = (k < 16);
      v5[1] = (k >= 3 && k < 19);
      d5[0] = v5[0] & (($urandom_range(0, 1)) == 1);
      d5[1] = v5[1] & (($urandom_range(0, 1)) == 1);
      step(d5, v5, 2'b00, 1'b0);
      chk("t5_done0", 32'(frame_done[0]), 32'((k + 1 == 8) || (k + 1 == 16)));
      chk("t5_done1", 32'(frame_done[1]), 32'((k + 1 == 11) || (k + 1 == 19)));
    end

    // 6. Reset after 5 bits on ch0, then a normal frame.
    do_reset();
    for (int k = 0; k < 5; k++) step(2'b01, 2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b01, 2'b00, 1'b1);
    chk("t6_rst_busy", 32'(busy[0]), 32'd0);
    chk("t6_rst_tog", 32'(toggle_cnt[0 +: CNT_W]), 32'd0);
    for (int k = 0; k < 8; k++) step({1'b0, k[0]}, 2'b01, 2'b00, 1'b0);
    chk("t6_done", 32'(frame_done[0]), 32'd1);
    chk("t6_err", 32'(parity_err[0]), 32'd0);

    // Randomized traffic with occasional aborts and resets.
    for (int k = 0; k < 600; k++) begin
      rd = NUM_CH'($urandom);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rv[ch] = ($urandom_range(0, 3) != 0);
        ra[ch] = ($urandom_range(0, 24) == 0);
      end
      rr = ($urandom_range(0, 149) == 0);
      step(rd, rv, ra, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Multi-channel serial parity checker, successor to the single-bit parity detector.
- Each of NUM_CH independent channels accepts one qualified serial bit per clock.
- Tracks running parity and counts parity-state transitions.
- Groups bits into frames of FRAME_LEN; the last bit of each frame is the parity bit.
- Flags a parity error at frame end.
- Sits between the serial deserialiser front end and the link-status/interrupt logic.

Parameters:
NUM_CH, 2, number of independent serial channels
FRAME_LEN, 8, bits per frame including the trailing parity bit (>=1)
ODD_PARITY, 0, 0 = frame must have an even count of 1s; 1 = frame must have an odd count
CNT_W, 6, width of each per-channel transition counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
data_in  in  NUM_CH  serial bit per channel (bit i = channel i)
valid_in  in  NUM_CH  data_in[i] accepted on a clk edge where valid_in[i]=1
abort  in  NUM_CH  discard channel i's partial frame
busy  out  NUM_CH  channel i is mid-frame
parity_out  out  NUM_CH  running parity of accepted bits in the current frame
frame_done  out  NUM_CH  one-cycle pulse: frame complete
parity_err  out  NUM_CH  result of the last completed frame; held until the next frame_done
toggle_cnt  out  NUM_CH*CNT_W  per-channel saturating count of parity transitions; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset values, all channels: busy=0, parity_out=0, frame_done=0, parity_err=0, toggle_cnt=0, internal bit counter=0.
- Per-channel FSM with two states:
  - IDLE: bit_cnt=0, busy=0.
  - RUN: 1 <= bit_cnt <= FRAME_LEN-1, busy=1.
- Accepted bit (valid_in=1, abort=0):
  - parity_out <= parity_out ^ data_in.
  - bit_cnt increments.
  - If data_in=1, the parity state toggles and toggle_cnt increments.
- toggle_cnt saturates at 2^CNT_W-1 and never wraps.
- toggle_cnt is cumulative across frames and is cleared only by rst.
- Transitions:
  - IDLE -> RUN on an accepted bit when FRAME_LEN>1.
  - RUN -> IDLE on an accepted bit when bit_cnt==FRAME_LEN-1 (final bit).
  - RUN -> IDLE on abort.
- Frame completion, on the final accepted bit:
  - Next cycle: frame_done=1 for exactly one cycle.
  - parity_err = (final parity != ODD_PARITY).
  - parity_out returns to 0 on that same cycle.
  - Latency from final bit edge to frame_done is 1 cycle.
- FRAME_LEN=1: every accepted bit completes a frame directly from IDLE; busy stays 0.
- Back-to-back frames: a bit accepted in the cycle frame_done is high starts the next frame; no gap cycle is required.
- Abort:
  - Returns the channel to IDLE, clears parity_out and bit_cnt.
  - No frame_done; parity_err unchanged; toggle_cnt unchanged.
  - abort together with valid_in: abort wins and the bit is dropped.
  - abort in IDLE: no effect.
- valid_in=0: the channel holds all state; gaps mid-frame are legal.
- Channels never interact; simultaneous events on different channels are processed independently in the same cycle.
- rst mid-frame: partial frame discarded and all outputs return to reset values on the next edge.

Optional Feature:
PARITY_ERR_CNT_EN
- Defined:
  - Adds parameter ERR_W (default 8).
  - Adds output err_cnt (NUM_CH*ERR_W): per-channel saturating count of frames completed with parity_err=1.
  - err_cnt increments in the same cycle frame_done is asserted with parity_err=1.
  - err_cnt is cleared by rst only.
- Undefined: the port, parameter and counters are absent; all other behaviour is identical.

Test Plan:
(All with NUM_CH=2, FRAME_LEN=8, ODD_PARITY=0, CNT_W=6.)
1. Good frame: ch0 bits 1,0,1,1,0,0,0,1 with valid continuous -> frame_done[0] pulses 1 cycle after the 8th bit, parity_err[0]=0, toggle_cnt ch0=4, busy[0] high for cycles 1-7.
2. Bad frame then gap: ch0 bits 1,0,0,0,0,0,0,0 with valid_in low for 3 cycles after bit 4 -> frame_done after bit 8, parity_err[0]=1, held through 5 idle cycles.
3. Abort: ch1 4 bits of 1, then abort together with valid, then 8 zeros -> no frame_done for the aborted frame; a single frame_done[1] with parity_err=0; toggle_cnt ch1=4.
4. Saturation: ch0 fed 80 ones (10 frames) -> toggle_cnt ch0 stops at 63; parity_err=0 on every frame.
5. Back-to-back and independence: ch0 and ch1 stream two frames each with no idle cycle, ch1 offset by 3 cycles -> frame_done pulses on cycles 8, 11, 16, 19; no cross-channel effect.
6. Reset mid-frame: rst asserted after 5 bits on ch0 -> all outputs 0 next edge; the following 8-bit frame is checked normally.
